// File: rtl/barrel_shifter_pipe.sv
// Two-stage valid/ready pipelined barrel shifter: rotate right/left, logical and
// arithmetic shift right, for any power-of-two WIDTH.
module barrel_shifter_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SW    = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] IN,
    input  logic [SW-1:0]    SHIFT,
    input  logic [1:0]       MODE,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    typedef enum logic [1:0] {
        MODE_ROR = 2'b00,
        MODE_ROL = 2'b01,
        MODE_SRL = 2'b10,
        MODE_SRA = 2'b11
    } mode_e;

    typedef struct packed {
        mode_e           mode;
        logic [SW-1:0]   shift;
        logic [WIDTH-1:0] data;
    } s1_t;

    logic             s1_valid_q, s1_valid_d;
    s1_t              s1_q, s1_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic             s1_en_c, s2_en_c;
    logic [WIDTH-1:0] shifted_c;

    // Log-depth shifter: level j conditionally shifts by 2^j, no registers between levels
    always_comb begin
        shifted_c = s1_q.data;
        for (int unsigned j = 0; j < SW; j++) begin
            if (s1_q.shift[j]) begin
                case (s1_q.mode)
                    MODE_ROR: shifted_c = (shifted_c >> (1 << j)) | (shifted_c << (WIDTH - (1 << j)));
                    MODE_ROL: shifted_c = (shifted_c << (1 << j)) | (shifted_c >> (WIDTH - (1 << j)));
                    MODE_SRL: shifted_c = shifted_c >> (1 << j);
                    MODE_SRA: shifted_c = WIDTH'($signed(shifted_c) >>> (1 << j));
                endcase
            end
        end
    end

    // Advance enables and next-state for both stages
    always_comb begin
        s2_en_c    = !s2_valid_q || OUT_READY;
        s1_en_c    = !s1_valid_q || s2_en_c;
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;

        if (s1_en_c) begin
            s1_valid_d = IN_VALID;
            if (IN_VALID) begin
                s1_d = '{mode: mode_e'(MODE), shift: SHIFT, data: IN};
            end
        end

        if (s2_en_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d = shifted_c;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
        end
    end

    assign IN_READY  = s1_en_c;
    assign OUT       = s2_q;
    assign OUT_VALID = s2_valid_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe: an 8-bit and a 32-bit instance side by side.
module tb_barrel_shifter_pipe;

    typedef struct {
        logic [31:0] exp;
        int          cyc;
    } sb_t;

    logic        clk;
    logic        rst_n;

    logic [7:0]  in8,  out8;
    logic [2:0]  sh8;
    logic [1:0]  md8;
    logic        iv8, ir8, ov8, ordy8;

    logic [31:0] in32, out32;
    logic [4:0]  sh32;
    logic [1:0]  md32;
    logic        iv32, ir32, ov32, ordy32;

    int  n_chk  = 0;
    int  n_fail = 0;
    int  cyc    = 0;
    int  occ8   = 0;
    int  occ32  = 0;
    int  pops8  = 0;
    bit  lat_chk = 0;
    sb_t q8[$];
    sb_t q32[$];

    barrel_shifter_pipe #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .RST_N(rst_n), .IN(in8), .SHIFT(sh8), .MODE(md8),
        .IN_VALID(iv8), .IN_READY(ir8), .OUT(out8), .OUT_VALID(ov8), .OUT_READY(ordy8)
    );

    barrel_shifter_pipe #(.WIDTH(32)) u_dut32 (
        .CLK(clk), .RST_N(rst_n), .IN(in32), .SHIFT(sh32), .MODE(md32),
        .IN_VALID(iv32), .IN_READY(ir32), .OUT(out32), .OUT_VALID(ov32), .OUT_READY(ordy32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bit-by-bit reference of the four modes for width w
    function automatic logic [31:0] model_f(input int w, input logic [31:0] x,
                                            input int k, input logic [1:0] m);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                2'b00:   r[i] = x[(i + k) % w];
                2'b01:   r[i] = x[(i - k + w) % w];
                2'b10:   r[i] = (i + k < w) ? x[(i + k) % 32] : 1'b0;
                default: r[i] = (i + k < w) ? x[(i + k) % 32] : x[w - 1];
            endcase
        end
        return r;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer
    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            occ8  = q8.size();
            occ32 = q32.size();
            if (ov8 && ordy8) begin
                n_chk++;
                pops8++;
                if (q8.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb8_unexpected: got out=%h with no item outstanding", out8);
                end else begin
                    e = q8.pop_front();
                    if (out8 !== e.exp[7:0]) begin
                        n_fail++;
                        $display("FAIL sb8_data: got %h, expected %h", out8, e.exp[7:0]);
                    end
                    if (lat_chk) begin
                        n_chk++;
                        if (cyc - e.cyc != 2) begin
                            n_fail++;
                            $display("FAIL sb8_latency: got %0d cycles, expected 2", cyc - e.cyc);
                        end
                    end
                end
            end
            if (ov32 && ordy32) begin
                n_chk++;
                if (q32.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb32_unexpected: got out=%h with no item outstanding", out32);
                end else begin
                    e = q32.pop_front();
                    if (out32 !== e.exp) begin
                        n_fail++;
                        $display("FAIL sb32_data: got %h, expected %h", out32, e.exp);
                    end
                end
            end
            if (iv8 && ir8)
                q8.push_back('{model_f(8, {24'h0, in8}, int'(sh8), md8), cyc});
            if (iv32 && ir32)
                q32.push_back('{model_f(32, in32, int'(sh32), md32), cyc});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic drain(output bit ok);
        iv8 = 1'b0; iv32 = 1'b0; ordy8 = 1'b1; ordy32 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1;
            ok = (q8.size() == 0) && (q32.size() == 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in8 = '0; sh8 = '0; md8 = '0; iv8 = 1'b0; ordy8 = 1'b1;
        in32 = '0; sh32 = '0; md32 = '0; iv32 = 1'b0; ordy32 = 1'b1;
        #3;
        n_chk += 4;
        if (ov8 !== 1'b0)   begin n_fail++; $display("FAIL rst_ov8: got %b, expected 0", ov8); end
        if (out8 !== 8'h0)  begin n_fail++; $display("FAIL rst_out8: got %h, expected 00", out8); end
        if (ov32 !== 1'b0)  begin n_fail++; $display("FAIL rst_ov32: got %b, expected 0", ov32); end
        if (out32 !== 32'h0) begin n_fail++; $display("FAIL rst_out32: got %h, expected 0", out32); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        n_chk += 3;
        if (ir8 !== 1'b1)  begin n_fail++; $display("FAIL rst_ir8: got %b, expected 1", ir8); end
        if (ir32 !== 1'b1) begin n_fail++; $display("FAIL rst_ir32: got %b, expected 1", ir32); end
        if (ov8 !== 1'b0)  begin n_fail++; $display("FAIL rst_ov8_rel: got %b, expected 0", ov8); end
        @(posedge clk); #1;
    endtask

    task automatic test_legacy();
        bit ok;
        lat_chk = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int x = 0; x < 256; x++) begin
                in8 = 8'(x); sh8 = 3'(k); md8 = 2'b00; iv8 = 1'b1; ordy8 = 1'b1;
                @(negedge clk); #1;
                n_chk++;
                if (ir8 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL legacy_ready: got %b, expected 1 (x=%0d k=%0d)", ir8, x, k);
                end
                @(posedge clk); #1;
            end
        end
        drain(ok);
        lat_chk = 1'b0;
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL legacy_drain: got %0d left, expected 0", q8.size()); end
    endtask

    task automatic test_modes();
        logic [1:0] ms [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
        logic [2:0] ks [8] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
        logic [7:0] es [8] = '{8'hD2, 8'hB4, 8'h12, 8'hF2, 8'h96, 8'h96, 8'h96, 8'h96};
        bit seen;
        for (int t = 0; t < 8; t++) begin
            in8 = 8'h96; sh8 = ks[t]; md8 = ms[t]; iv8 = 1'b1; ordy8 = 1'b1;
            @(posedge clk); #1;
            iv8 = 1'b0; md8 = ~ms[t]; sh8 = ~ks[t];
            seen = 1'b0;
            for (int w = 0; w < 6 && !seen; w++) begin
                @(negedge clk); #1;
                seen = ov8;
                if (!seen) begin @(posedge clk); #1; end
            end
            n_chk++;
            if (!seen || out8 !== es[t]) begin
                n_fail++;
                $display("FAIL mode_%0d: got %h valid=%b, expected %h (mode=%b k=%0d)",
                         t, out8, seen, es[t], ms[t], ks[t]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] xs [6] = '{8'h96, 8'h81, 8'h3C, 8'hF0, 8'h01, 8'h7E};
        logic [2:0] ks [6] = '{3'd1, 3'd7, 3'd2, 3'd4, 3'd5, 3'd3};
        logic [1:0] ms [6] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11};
        int sent = 0, p0;
        bit stall_prev = 0, saw_low = 0, ok;
        logic [7:0] held = '0;
        p0 = pops8;
        for (int c = 0; c < 40 && !(sent == 6 && q8.size() == 0 && c > 8); c++) begin
            iv8 = (sent < 6);
            in8 = xs[sent % 6]; sh8 = ks[sent % 6]; md8 = ms[sent % 6];
            ordy8 = !(c >= 3 && c <= 7);
            @(negedge clk); #1;
            n_chk++;
            if (ir8 !== !(occ8 == 2 && !ordy8)) begin
                n_fail++;
                $display("FAIL bp_ready c=%0d: got %b, expected %b", c, ir8, !(occ8 == 2 && !ordy8));
            end
            if (stall_prev) begin
                n_chk++;
                if (out8 !== held || ov8 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_stable c=%0d: got %h valid=%b, expected %h valid=1", c, out8, ov8, held);
                end
            end
            if (!ir8) saw_low = 1'b1;
            stall_prev = ov8 && !ordy8;
            held = out8;
            if (iv8 && ir8) sent++;
            @(posedge clk); #1;
        end
        drain(ok);
        n_chk += 3;
        if (!saw_low) begin n_fail++; $display("FAIL bp_ir_low: got never low, expected low while full"); end
        if (pops8 - p0 != 6) begin n_fail++; $display("FAIL bp_count: got %0d results, expected 6", pops8 - p0); end
        if (!ok) begin n_fail++; $display("FAIL bp_drain: got %0d left, expected 0", q8.size()); end
    endtask

    task automatic test_throughput32();
        bit ok;
        for (int c = 0; c < 204; c++) begin
            iv32 = (c < 200); ordy32 = 1'b1;
            if (c == 0) begin
                in32 = 32'h8000_0001; sh32 = 5'd31; md32 = 2'b11;
            end else if (c == 1) begin
                in32 = 32'h8000_0001; sh32 = 5'd31; md32 = 2'b00;
            end else begin
                in32 = $urandom; sh32 = 5'($urandom_range(0, 31)); md32 = 2'($urandom_range(0, 3));
            end
            @(negedge clk); #1;
            if (c < 200) begin
                n_chk++;
                if (ir32 !== 1'b1) begin n_fail++; $display("FAIL tp_ready c=%0d: got %b, expected 1", c, ir32); end
            end
            if (c >= 2 && c < 202) begin
                n_chk++;
                if (ov32 !== 1'b1) begin n_fail++; $display("FAIL tp_valid c=%0d: got %b, expected 1", c, ov32); end
            end
            if (c == 2) begin
                n_chk++;
                if (out32 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL tp_sra31: got %h, expected ffffffff", out32); end
            end
            if (c == 3) begin
                n_chk++;
                if (out32 !== 32'h0000_0003) begin n_fail++; $display("FAIL tp_ror31: got %h, expected 00000003", out32); end
            end
            @(posedge clk); #1;
        end
        drain(ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL tp_drain: got %0d left, expected 0", q32.size()); end
    endtask

    task automatic test_bubbles();
        bit ok;
        for (int c = 0; c < 10000; c++) begin
            iv8  = ($urandom_range(0, 99) < 60);
            ordy8 = ($urandom_range(0, 99) < 55);
            in8  = 8'($urandom); sh8 = 3'($urandom); md8 = 2'($urandom);
            iv32 = ($urandom_range(0, 99) < 70);
            ordy32 = ($urandom_range(0, 99) < 45);
            in32 = $urandom; sh32 = 5'($urandom); md32 = 2'($urandom);
            @(negedge clk); #1;
            n_chk += 2;
            if (ir8 !== !(occ8 == 2 && !ordy8)) begin
                n_fail++;
                $display("FAIL bub_ready8 c=%0d: got %b, expected %b", c, ir8, !(occ8 == 2 && !ordy8));
            end
            if (ir32 !== !(occ32 == 2 && !ordy32)) begin
                n_fail++;
                $display("FAIL bub_ready32 c=%0d: got %b, expected %b", c, ir32, !(occ32 == 2 && !ordy32));
            end
            @(posedge clk); #1;
        end
        drain(ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL bub_drain: got %0d/%0d left, expected 0", q8.size(), q32.size()); end
    endtask

    task automatic test_reset_midstream();
        bit ok;
        for (int c = 0; c < 3; c++) begin
            in8 = 8'hA5 + 8'(c); sh8 = 3'd1; md8 = 2'b00; iv8 = 1'b1; ordy8 = 1'b0;
            @(posedge clk); #1;
        end
        iv8 = 1'b0;
        @(negedge clk); #1;
        n_chk += 2;
        if (ov8 !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b, expected 1", ov8); end
        if (ir8 !== 1'b0) begin n_fail++; $display("FAIL mid_pre_ready: got %b, expected 0", ir8); end
        #2 rst_n = 1'b0;
        #1;
        n_chk += 2;
        if (ov8 !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_valid: got %b, expected 0", ov8); end
        if (out8 !== 8'h0) begin n_fail++; $display("FAIL mid_rst_out: got %h, expected 00", out8); end
        q8.delete();
        q32.delete();
        ordy8 = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            n_chk += 2;
            if (ov8 !== 1'b0) begin n_fail++; $display("FAIL mid_stale c=%0d: got valid=%b, expected 0", c, ov8); end
            if (ir8 !== 1'b1) begin n_fail++; $display("FAIL mid_ready c=%0d: got %b, expected 1", c, ir8); end
            @(posedge clk); #1;
        end
        in8 = 8'h0F; sh8 = 3'd2; md8 = 2'b01; iv8 = 1'b1;
        @(posedge clk); #1;
        drain(ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL mid_after: got %0d left, expected 0", q8.size()); end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_modes();
        test_backpressure();
        test_throughput32();
        test_bubbles();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
